// File: rtl/run_ctrl.sv
// Run-control scheduler: debounces the step/continue/check buttons and sequences
// the CPU clock enable for free run with breakpoint, single step and debug-address scan.
module run_ctrl #(
    parameter int unsigned DB_CNT = 3,
    parameter int unsigned DB_W   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        cont,
    input  logic        chk,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic [7:0]  scan_lo,
    input  logic [7:0]  scan_hi,
    output logic        cpu_ce,
    output logic        pause,
    output logic [7:0]  scan_addr,
    output logic        scan_valid
);

    localparam int unsigned NB = 3;
    localparam int unsigned AW = 8;

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_SCAN  = 2'd3
    } state_t;

    logic [NB-1:0]   raw;
    logic [NB-1:0]   sync1;
    logic [NB-1:0]   sync2;
    logic [NB-1:0]   level;
    logic [NB-1:0]   pulse;
    logic [DB_W-1:0] cnt [NB];

    logic step_p;
    logic cont_p;
    logic chk_p;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] scan_addr_q;
    logic [AW-1:0] scan_addr_d;
    logic          skip_q;
    logic          skip_d;
    logic          pause_q;
    logic          scan_valid_q;
    logic          ce_c;
    logic          bp_hit_c;

    assign raw    = {chk, cont, step};
    assign step_p = pulse[0];
    assign cont_p = pulse[1];
    assign chk_p  = pulse[2];

    // Synchronize and debounce each button; pulse marks the debounced rising level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            pulse <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NB; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] != level[i]) begin
                    if (cnt[i] == DB_W'(DB_CNT - 1)) begin
                        level[i] <= sync2[i];
                        cnt[i]   <= '0;
                        pulse[i] <= sync2[i];
                    end else begin
                        cnt[i] <= cnt[i] + DB_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign bp_hit_c = bp_en && (pc == bp_addr);

    // State, scan pointer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_PAUSE;
            scan_addr_q  <= '0;
            skip_q       <= 1'b0;
            pause_q      <= 1'b1;
            scan_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_addr_q  <= scan_addr_d;
            skip_q       <= skip_d;
            pause_q      <= (state_d != S_RUN);
            scan_valid_q <= (state_d == S_SCAN);
        end
    end

    // Next-state and clock-enable decode.
    always_comb begin
        state_d     = state_q;
        scan_addr_d = scan_addr_q;
        skip_d      = skip_q;
        ce_c        = 1'b0;
        case (state_q)
            S_PAUSE: begin
                if (cont_p) begin
                    state_d = S_RUN;
                    skip_d  = 1'b1;
                end else if (step_p) begin
                    state_d = S_STEP;
                end else if (chk_p) begin
                    state_d     = S_SCAN;
                    scan_addr_d = scan_lo;
                end
            end
            S_RUN: begin
                // skip lets a resume step over the breakpoint it stopped on.
                skip_d = 1'b0;
                ce_c   = !(bp_hit_c && !skip_q);
                if ((bp_hit_c && !skip_q) || cont_p) begin
                    state_d = S_PAUSE;
                end
            end
            S_STEP: begin
                ce_c    = 1'b1;
                state_d = S_PAUSE;
            end
            S_SCAN: begin
                if (chk_p || (scan_addr_q == scan_hi) || (scan_addr_q == 8'hFF)) begin
                    state_d = S_PAUSE;
                end else begin
                    scan_addr_d = scan_addr_q + AW'(1);
                end
            end
            default: begin
                state_d = S_PAUSE;
            end
        endcase
    end

    // Reset suppresses the enable in the cycle it is asserted.
    assign cpu_ce     = ce_c && !rst;
    assign pause      = pause_q;
    assign scan_addr  = scan_addr_q;
    assign scan_valid = scan_valid_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: debounce timing, step, breakpoint run/resume, scan walks,
// button priority and reset abort.
module tb_run_ctrl;

    logic        clk;
    logic        rst;
    logic        step;
    logic        cont;
    logic        chk;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic [7:0]  scan_lo;
    logic [7:0]  scan_hi;
    logic        cpu_ce;
    logic        pause;
    logic [7:0]  scan_addr;
    logic        scan_valid;

    int checks;
    int failures;
    int ce_count;
    logic prev_ce;

    run_ctrl #(.DB_CNT(3), .DB_W(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .cont       (cont),
        .chk        (chk),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .scan_lo    (scan_lo),
        .scan_hi    (scan_hi),
        .cpu_ce     (cpu_ce),
        .pause      (pause),
        .scan_addr  (scan_addr),
        .scan_valid (scan_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        step     = 1'b0;
        cont     = 1'b0;
        chk      = 1'b0;
        bp_en    = 1'b0;
        bp_addr  = 32'h0;
        pc       = 32'h0;
        scan_lo  = 8'h0;
        scan_hi  = 8'h0;

        do_reset();
        check_val("rst_ce", 32'(cpu_ce), 32'd0);
        check_val("rst_pause", 32'(pause), 32'd1);
        check_val("rst_addr", 32'(scan_addr), 32'd0);
        check_val("rst_valid", 32'(scan_valid), 32'd0);

        // Step: raw high in cycles 0..3, pulse in cycle 5, single enable in cycle 6.
        for (int k = 0; k < 14; k++) begin
            next_cycle();
            step = (k < 4);
            #1;
            check_val($sformatf("step_ce_%0d", k), 32'(cpu_ce), 32'(k == 6));
            check_val($sformatf("step_pause_%0d", k), 32'(pause), 32'd1);
        end

        // Two-cycle glitch must not be accepted.
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            cont = (k < 2);
            #1;
            check_val($sformatf("glitch_ce_%0d", k), 32'(cpu_ce), 32'd0);
            check_val($sformatf("glitch_pause_%0d", k), 32'(pause), 32'd1);
        end

        // Run to breakpoint at 0x300C: three enables, stop with the bp instruction unexecuted.
        bp_en    = 1'b1;
        bp_addr  = 32'h0000_300C;
        pc       = 32'h0000_3000;
        prev_ce  = 1'b0;
        ce_count = 0;
        for (int k = 0; k < 30; k++) begin
            next_cycle();
            cont = (k < 4);
            if (prev_ce) pc = pc + 32'd4;
            #1;
            prev_ce = cpu_ce;
            if (cpu_ce) ce_count++;
            check_val($sformatf("bp_ce_%0d", k), 32'(cpu_ce), 32'(k >= 6 && k <= 8));
            check_val($sformatf("bp_pause_%0d", k), 32'(pause), 32'(!(k >= 6 && k <= 9)));
        end
        check_val("bp_ce_count", 32'(ce_count), 32'd3);
        check_val("bp_stop_pc", pc, 32'h0000_300C);

        // Resume from the breakpoint executes past it.
        for (int k = 0; k < 13; k++) begin
            next_cycle();
            cont = (k < 4);
            if (prev_ce) pc = pc + 32'd4;
            #1;
            prev_ce = cpu_ce;
            check_val($sformatf("resume_ce_%0d", k), 32'(cpu_ce), 32'(k >= 6));
            check_val($sformatf("resume_pause_%0d", k), 32'(pause), 32'(k < 6));
        end
        check_val("resume_pc", pc, 32'h0000_3024);

        // Reset during RUN aborts at the next edge.
        rst = 1'b1;
        next_cycle();
        #1;
        check_val("rstrun_ce", 32'(cpu_ce), 32'd0);
        check_val("rstrun_pause", 32'(pause), 32'd1);
        check_val("rstrun_addr", 32'(scan_addr), 32'd0);
        rst   = 1'b0;
        bp_en = 1'b0;
        next_cycle();

        // Scan 0x04..0x07, then hold the last address.
        scan_lo = 8'h04;
        scan_hi = 8'h07;
        for (int k = 0; k < 15; k++) begin
            next_cycle();
            chk = (k < 4);
            #1;
            check_val($sformatf("scan_valid_%0d", k), 32'(scan_valid), 32'(k >= 6 && k <= 9));
            check_val($sformatf("scan_addr_%0d", k), 32'(scan_addr),
                      (k < 6) ? 32'd0 : ((k <= 9) ? 32'(4 + k - 6) : 32'd7));
            check_val($sformatf("scan_ce_%0d", k), 32'(cpu_ce), 32'd0);
            check_val($sformatf("scan_pause_%0d", k), 32'(pause), 32'd1);
        end

        // Scan with hi below lo stops at 0xFF without wrapping.
        scan_lo = 8'hFE;
        scan_hi = 8'h01;
        for (int k = 0; k < 15; k++) begin
            next_cycle();
            chk = (k < 4);
            #1;
            check_val($sformatf("wrap_valid_%0d", k), 32'(scan_valid), 32'(k == 6 || k == 7));
            check_val($sformatf("wrap_addr_%0d", k), 32'(scan_addr),
                      (k < 6) ? 32'h07 : ((k == 6) ? 32'hFE : 32'hFF));
        end

        // Simultaneous cont and step: continue wins.
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            cont = (k < 4);
            step = (k < 4);
            #1;
            check_val($sformatf("prio_pause_%0d", k), 32'(pause), 32'(k < 6));
            check_val($sformatf("prio_ce_%0d", k), 32'(cpu_ce), 32'(k >= 6));
        end
        do_reset();
        #1;
        check_val("end_pause", 32'(pause), 32'd1);
        check_val("end_ce", 32'(cpu_ce), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
